// File: rtl/pulse_qualifier.sv
// Synchronises and debounces an asynchronous external level, emitting one
// registered strobe per accepted rising transition plus a saturating event count.
module pulse_qualifier #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 2500000,
    parameter int COUNT_WIDTH     = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in,
    input  logic                   enable,
    input  logic                   clear_count,
    output logic                   pulse,
    output logic                   level,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   overflow
);

    // state    | meaning
    // LOW      | level = 0, waiting for s = 1
    // RISE_CHK | s = 1 seen, counting consecutive high samples
    // HIGH     | level = 1, waiting for s = 0
    // FALL_CHK | s = 0 seen, counting consecutive low samples
    typedef enum logic [1:0] {
        LOW      = 2'd0,
        RISE_CHK = 2'd1,
        HIGH     = 2'd2,
        FALL_CHK = 2'd3
    } state_t;

    localparam logic [31:0] DB = 32'(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q, state_d;
    logic [31:0]            cnt_q, cnt_d;
    logic                   rise_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LOW;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter saturates at DB so a stalled check state can never wrap it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        unique case (state_q)
            LOW: begin
                if (s) begin
                    cnt_d = 32'd1;
                    if (DB == 32'd1) begin
                        state_d = HIGH;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = RISE_CHK;
                    end
                end
            end
            RISE_CHK: begin
                if (!s) begin
                    cnt_d   = '0;
                    state_d = LOW;
                end else begin
                    if (cnt_q < DB) cnt_d = cnt_q + 32'd1;
                    if (cnt_q + 32'd1 >= DB) begin
                        state_d = HIGH;
                        rise_d  = 1'b1;
                    end
                end
            end
            HIGH: begin
                if (!s) begin
                    cnt_d = 32'd1;
                    if (DB == 32'd1) begin
                        state_d = LOW;
                    end else begin
                        state_d = FALL_CHK;
                    end
                end
            end
            FALL_CHK: begin
                if (s) begin
                    cnt_d   = '0;
                    state_d = HIGH;
                end else begin
                    if (cnt_q < DB) cnt_d = cnt_q + 32'd1;
                    if (cnt_q + 32'd1 >= DB) state_d = LOW;
                end
            end
            default: begin
                state_d = LOW;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level <= 1'b0;
            busy  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            level <= (state_d == HIGH) || (state_d == FALL_CHK);
            busy  <= (state_d == RISE_CHK) || (state_d == FALL_CHK);
            pulse <= rise_d && enable;
        end
    end

    // A clear coinciding with a pulse keeps that event as the first new count.
    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear_count) begin
            count    <= {{(COUNT_WIDTH-1){1'b0}}, pulse};
            overflow <= 1'b0;
        end else if (pulse) begin
            if (count == '1) begin
                overflow <= 1'b1;
            end else begin
                count <= count + COUNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_pulse_qualifier.sv
// Scoreboard bench for pulse_qualifier: expected counts are queued from a small
// model as presses are driven and compared against counts observed after each pulse.
module tb_pulse_qualifier;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, in_a, enable, clear_count;
    logic       pulse, level, busy, overflow;
    logic [3:0] count;

    logic       reset1, in_b, enable1, clear1;
    logic       pulse1, level1, busy1, overflow1;
    logic [3:0] count1;

    pulse_qualifier #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .COUNT_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .in(in_a), .enable(enable), .clear_count(clear_count),
        .pulse(pulse), .level(level), .busy(busy), .count(count), .overflow(overflow)
    );

    pulse_qualifier #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .COUNT_WIDTH(4)) dut1 (
        .clk(clk), .reset(reset1), .in(in_b), .enable(enable1), .clear_count(clear1),
        .pulse(pulse1), .level(level1), .busy(busy1), .count(count1), .overflow(overflow1)
    );

    int checks = 0;
    int passes = 0;
    int np = 0;
    int np1 = 0;
    logic pulse_prev = 1'b0;
    int obs_q[$];
    int exp_q[$];
    int mcount;
    bit movf;

    // Monitor: count pulses and record the count value the cycle after each pulse.
    always @(negedge clk) begin
        if (pulse_prev) obs_q.push_back(int'(count));
        pulse_prev <= (pulse === 1'b1);
        if (pulse === 1'b1) np <= np + 1;
        if (pulse1 === 1'b1) np1 <= np1 + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_press(input bit clr);
        if (clr) begin
            mcount = 1;
            movf   = 1'b0;
        end else if (mcount == 15) begin
            movf = 1'b1;
        end else begin
            mcount = mcount + 1;
        end
        exp_q.push_back(mcount);
    endtask

    task automatic press(input int hi, input int lo);
        in_a = 1'b1;
        tick(hi);
        in_a = 1'b0;
        tick(lo);
    endtask

    task automatic test_reset;
        reset = 1'b1; in_a = 1'b0; enable = 1'b1; clear_count = 1'b0;
        reset1 = 1'b1; in_b = 1'b0; enable1 = 1'b1; clear1 = 1'b0;
        tick(3);
        checks++; if ({level, pulse, busy, overflow} !== 4'b0000) $display("FAIL reset_flags: got %b expected 0000", {level, pulse, busy, overflow}); else passes++;
        checks++; if (count !== 4'd0) $display("FAIL reset_count: got %0d expected 0", count); else passes++;
        checks++; if ({level1, pulse1, busy1, count1} !== 7'd0) $display("FAIL reset_dut1: got %b expected 0", {level1, pulse1, busy1, count1}); else passes++;
        reset = 1'b0; reset1 = 1'b0;
        tick(2);
        checks++; if ({level, busy} !== 2'b00) $display("FAIL idle_after_reset: got %b expected 00", {level, busy}); else passes++;
        mcount = 0; movf = 1'b0;
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_latency;
        int v;
        in_a = 1'b1;
        model_press(1'b0);
        for (int e = 1; e <= 8; e++) begin
            tick(1);
            checks++; if (busy !== ((e >= 3 && e <= 5) ? 1'b1 : 1'b0)) $display("FAIL lat_busy edge %0d: got %b", e, busy); else passes++;
            checks++; if (level !== ((e >= 6) ? 1'b1 : 1'b0)) $display("FAIL lat_level edge %0d: got %b", e, level); else passes++;
            checks++; if (pulse !== ((e == 6) ? 1'b1 : 1'b0)) $display("FAIL lat_pulse edge %0d: got %b", e, pulse); else passes++;
        end
        tick(12);
        checks++; if (np !== 1) $display("FAIL lat_single_pulse: got %0d pulses expected 1", np); else passes++;
        in_a = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            tick(1);
            checks++; if (level !== ((e < 6) ? 1'b1 : 1'b0)) $display("FAIL fall_level edge %0d: got %b", e, level); else passes++;
            checks++; if (pulse !== 1'b0) $display("FAIL fall_pulse edge %0d: got %b expected 0", e, pulse); else passes++;
        end
        checks++;
        if (obs_q.size() == 0 || exp_q.size() == 0) $display("FAIL lat_scoreboard: obs %0d exp %0d entries", obs_q.size(), exp_q.size());
        else begin
            v = obs_q.pop_front();
            if (v !== exp_q.pop_front()) $display("FAIL lat_scoreboard: got %0d expected %0d", v, mcount); else passes++;
        end
    endtask

    task automatic test_glitch;
        int np0, v;
        bit saw_busy, saw_level;
        np0 = np; saw_busy = 1'b0; saw_level = 1'b0;
        in_a = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick(1);
            if (e == 3) in_a = 1'b0;
            saw_busy  = saw_busy | (busy === 1'b1);
            saw_level = saw_level | (level === 1'b1);
        end
        checks++; if (saw_busy !== 1'b1) $display("FAIL glitch_busy: got %b expected 1", saw_busy); else passes++;
        checks++; if (saw_level !== 1'b0) $display("FAIL glitch_level: got %b expected 0", saw_level); else passes++;
        checks++; if (np !== np0) $display("FAIL glitch_pulse: got %0d pulses expected %0d", np, np0); else passes++;
        checks++; if (int'(count) !== mcount) $display("FAIL glitch_count: got %0d expected %0d", count, mcount); else passes++;
        press(4, 10);
        model_press(1'b0);
        checks++; if (np !== np0 + 1) $display("FAIL min_press_pulse: got %0d pulses expected %0d", np, np0 + 1); else passes++;
        checks++;
        if (obs_q.size() == 0 || exp_q.size() == 0) $display("FAIL min_press_scoreboard: obs %0d exp %0d entries", obs_q.size(), exp_q.size());
        else begin
            v = obs_q.pop_front();
            if (v !== exp_q.pop_front()) $display("FAIL min_press_scoreboard: got %0d expected %0d", v, mcount); else passes++;
        end
    endtask

    task automatic test_saturation;
        int v;
        bit found;
        reset = 1'b1; tick(2); reset = 1'b0; tick(1);
        mcount = 0; movf = 1'b0;
        obs_q.delete(); exp_q.delete();
        for (int i = 1; i <= 16; i++) begin
            press(6, 8);
            model_press(1'b0);
            checks++;
            if (obs_q.size() == 0 || exp_q.size() == 0) $display("FAIL sat_scoreboard press %0d: obs %0d exp %0d entries", i, obs_q.size(), exp_q.size());
            else begin
                v = obs_q.pop_front();
                if (v !== exp_q.pop_front()) $display("FAIL sat_scoreboard press %0d: got %0d expected %0d", i, v, mcount); else passes++;
            end
            if (i == 15) begin
                checks++; if ({overflow, count} !== {1'b0, 4'd15}) $display("FAIL sat_15: got ovf %b count %0d expected 0/15", overflow, count); else passes++;
            end
        end
        checks++; if ({overflow, count} !== {movf, 4'(mcount)}) $display("FAIL sat_16: got ovf %b count %0d expected %b/%0d", overflow, count, movf, mcount); else passes++;
        found = 1'b0;
        in_a = 1'b1;
        for (int k = 0; k < 20 && !found; k++) begin
            tick(1);
            if (pulse === 1'b1) begin
                clear_count = 1'b1;
                tick(1);
                clear_count = 1'b0;
                found = 1'b1;
            end
        end
        in_a = 1'b0;
        tick(8);
        model_press(1'b1);
        checks++; if (found !== 1'b1) $display("FAIL clear_pulse_timeout: got no pulse within 20 cycles"); else passes++;
        checks++; if ({overflow, count} !== {movf, 4'(mcount)}) $display("FAIL clear_with_pulse: got ovf %b count %0d expected %b/%0d", overflow, count, movf, mcount); else passes++;
        checks++;
        if (obs_q.size() == 0 || exp_q.size() == 0) $display("FAIL clear_scoreboard: obs %0d exp %0d entries", obs_q.size(), exp_q.size());
        else begin
            v = obs_q.pop_front();
            if (v !== exp_q.pop_front()) $display("FAIL clear_scoreboard: got %0d expected %0d", v, mcount); else passes++;
        end
    endtask

    task automatic test_enable;
        int np0, v;
        logic [3:0] c0;
        np0 = np; c0 = count;
        enable = 1'b0;
        in_a = 1'b1;
        tick(6);
        checks++; if ({level, pulse} !== 2'b10) $display("FAIL dis_level_pulse: got %b expected 10", {level, pulse}); else passes++;
        in_a = 1'b0;
        tick(8);
        checks++; if (level !== 1'b0) $display("FAIL dis_level_fall: got %b expected 0", level); else passes++;
        checks++; if (np !== np0) $display("FAIL dis_pulse: got %0d pulses expected %0d", np, np0); else passes++;
        checks++; if (count !== c0) $display("FAIL dis_count: got %0d expected %0d", count, c0); else passes++;
        enable = 1'b1;
        press(6, 8);
        model_press(1'b0);
        checks++; if (np !== np0 + 1) $display("FAIL reen_pulse: got %0d pulses expected %0d", np, np0 + 1); else passes++;
        checks++;
        if (obs_q.size() == 0 || exp_q.size() == 0) $display("FAIL reen_scoreboard: obs %0d exp %0d entries", obs_q.size(), exp_q.size());
        else begin
            v = obs_q.pop_front();
            if (v !== exp_q.pop_front()) $display("FAIL reen_scoreboard: got %0d expected %0d", v, mcount); else passes++;
        end
    endtask

    task automatic test_reset_mid;
        int v;
        in_a = 1'b1;
        tick(3);
        checks++; if (busy !== 1'b1) $display("FAIL mid_busy: got %b expected 1", busy); else passes++;
        reset = 1'b1;
        for (int e = 1; e <= 2; e++) begin
            tick(1);
            checks++; if ({level, pulse, busy, overflow, count} !== 8'd0) $display("FAIL mid_reset_outputs cycle %0d: got %b expected 0", e, {level, pulse, busy, overflow, count}); else passes++;
        end
        reset = 1'b0;
        mcount = 0; movf = 1'b0;
        obs_q.delete(); exp_q.delete();
        model_press(1'b0);
        for (int e = 1; e <= 7; e++) begin
            tick(1);
            checks++; if (pulse !== ((e == 6) ? 1'b1 : 1'b0)) $display("FAIL requal_pulse edge %0d: got %b", e, pulse); else passes++;
        end
        tick(6);
        in_a = 1'b0;
        tick(8);
        checks++;
        if (obs_q.size() == 0 || exp_q.size() == 0) $display("FAIL requal_scoreboard: obs %0d exp %0d entries", obs_q.size(), exp_q.size());
        else begin
            v = obs_q.pop_front();
            if (v !== exp_q.pop_front()) $display("FAIL requal_scoreboard: got %0d expected %0d", v, mcount); else passes++;
        end
    endtask

    task automatic test_fast;
        int n0;
        in_b = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick(1);
            checks++; if (pulse1 !== ((e == 4) ? 1'b1 : 1'b0)) $display("FAIL fast_pulse edge %0d: got %b", e, pulse1); else passes++;
            checks++; if (level1 !== ((e >= 4) ? 1'b1 : 1'b0)) $display("FAIL fast_level edge %0d: got %b", e, level1); else passes++;
        end
        in_b = 1'b0;
        tick(6);
        checks++; if (level1 !== 1'b0) $display("FAIL fast_fall: got %b expected 0", level1); else passes++;
        n0 = np1;
        for (int i = 0; i < 16; i++) begin
            in_b = (i % 2 == 0);
            tick(1);
        end
        in_b = 1'b0;
        tick(6);
        checks++; if (np1 !== n0 + 8) $display("FAIL alt_pulses: got %0d expected %0d", np1 - n0, 8); else passes++;
        checks++; if ({level1, busy1} !== 2'b00) $display("FAIL alt_idle: got %b expected 00", {level1, busy1}); else passes++;
        checks++; if (count1 !== 4'd9) $display("FAIL alt_count: got %0d expected 9", count1); else passes++;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_saturation();
        test_enable();
        test_reset_mid();
        test_fast();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
